zero_flag_pipe: RTL and testbench

//  Parametrised, pipelined zero detector for the ALU flag path; the next

---
 rtl/zero_flag_pipe.sv | 170 +++++++++++++++++
 tb/tb_zero_flag_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_flag_pipe.sv
// ---------------------------------------------------------------------------
// zero_flag_pipe
//
// Pipelined zero detector for the ALU flag path. A WIDTH-bit value is padded
// with zeros on the MSB side to GROUP**LEVELS bits. It is then reduced by
// LEVELS registered stages. Each stage ORs GROUP-bit slices of the previous
// stage. The final single OR bit is inverted to give the zero flag. The sign
// bit (negative flag) travels alongside its sample. A saturating counter
// tallies delivered zero results.
//
// Parameters
//   WIDTH    data width tested for zero (>= 2)
//   GROUP    fan-in of each reduction stage (>= 2)
//   COUNT_W  width of the zero-result counter
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   in_valid    in   in_data valid this cycle
//   in_ready    out  block accepts in_data this cycle
//   in_data     in   WIDTH-bit value to test
//   out_valid   out  flags valid
//   out_ready   in   consumer takes the flags this cycle
//   zero        out  1 when the sample was all zeros
//   negative    out  MSB of the same sample
//   clr_count   in   synchronous clear of zero_count (wins over increment)
//   zero_count  out  saturating count of delivered zero results
// ---------------------------------------------------------------------------
module zero_flag_pipe #(
  parameter int WIDTH   = 64,
  parameter int GROUP   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               zero,
  output logic               negative,
  input  logic               clr_count,
  output logic [COUNT_W-1:0] zero_count
);

  // Smallest number of GROUP-input levels that covers WIDTH bits (at least 1).
  function automatic int calc_levels(input int w, input int g);
    int     l;
    longint span;
    l    = 0;
    span = 1;
    while (span < longint'(w)) begin
      span = span * longint'(g);
      l++;
    end
    if (l < 1) l = 1;
    return l;
  endfunction

  function automatic int pow_int(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // All stage vectors are packed into one flat bus. Stage j is
  // GROUP**(lv-j) bits wide. This returns the bit offset of stage k.
  function automatic int stage_off(input int k, input int g, input int lv);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off = off + pow_int(g, lv - j);
    return off;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, GROUP);
  localparam int PADW   = pow_int(GROUP, LEVELS);
  localparam int BUSW   = stage_off(LEVELS + 1, GROUP, LEVELS);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  wire [BUSW-1:0] data_bus;
  wire [LEVELS:0] valid_bus;
  wire [LEVELS:0] neg_bus;

  logic stall;
  logic advance;
  logic deliver;

  // The whole pipe freezes while the consumer refuses a valid result.
  // No bubble squeezing: one global enable keeps every stage in lockstep.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;
  assign deliver  = out_valid & out_ready;

  assign valid_bus[0] = in_valid;
  assign neg_bus[0]   = in_data[WIDTH-1];

  // Stage 0 is the raw input. It is zero-padded on the MSB side so that
  // every stage divides evenly by GROUP. Zero bits never change an OR.
  if (PADW > WIDTH) begin : g_pad
    assign data_bus[PADW-1:WIDTH] = '0;
    assign data_bus[WIDTH-1:0]    = in_data;
  end else begin : g_nopad
    assign data_bus[PADW-1:0] = in_data;
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    localparam int IW   = pow_int(GROUP, LEVELS - k + 1);
    localparam int OW   = pow_int(GROUP, LEVELS - k);
    localparam int IOFF = stage_off(k - 1, GROUP, LEVELS);
    localparam int OOFF = stage_off(k, GROUP, LEVELS);

    logic [IW-1:0] src;
    logic [OW-1:0] or_vec;
    logic [OW-1:0] data_q;
    logic          valid_q;
    logic          neg_q;

    assign src = data_bus[IOFF +: IW];

    // OR-reduce each GROUP-bit slice of the previous stage.
    always_comb begin
      or_vec = '0;
      for (int i = 0; i < OW; i++) begin
        or_vec[i] = |src[i*GROUP +: GROUP];
      end
    end

    // Data and sign only load with a real sample. A bubble just clears the
    // valid bit, so the flag outputs keep their last values across idle
    // cycles. The last stage resets its OR bit to 1 so that zero reads 0
    // straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        neg_q   <= 1'b0;
        data_q  <= (k == LEVELS) ? {OW{1'b1}} : {OW{1'b0}};
      end else if (advance) begin
        valid_q <= valid_bus[k-1];
        if (valid_bus[k-1]) begin
          data_q <= or_vec;
          neg_q  <= neg_bus[k-1];
        end
      end
    end

    assign data_bus[OOFF +: OW] = data_q;
    assign valid_bus[k]         = valid_q;
    assign neg_bus[k]           = neg_q;
  end

  assign out_valid = valid_bus[LEVELS];
  assign zero      = ~data_bus[BUSW-1];
  assign negative  = neg_bus[LEVELS];

  // The count only moves when a zero result is actually handed over.
  // A clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_count <= '0;
    end else if (clr_count) begin
      zero_count <= '0;
    end else if (deliver && zero && (zero_count != COUNT_MAX)) begin
      zero_count <= zero_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_zero_flag_pipe.sv
// ---------------------------------------------------------------------------
// tb_zero_flag_pipe
//
// Self-checking bench for zero_flag_pipe.
//   dut   : WIDTH=64, GROUP=4, COUNT_W=8 (3 stages)
//   dut_p : WIDTH=37, GROUP=4, COUNT_W=2 (padded, 3 stages, tiny counter)
// Inputs change on the falling edge. Outputs are sampled shortly after
// that, well away from the rising edge. Expected flags come from the sample
// value itself (value == 0, MSB), and ordering comes from a queue of
// accepted samples.
// ---------------------------------------------------------------------------
module tb_zero_flag_pipe;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, zero, negative, clr_count;
  logic [63:0] in_data;
  logic [7:0]  zero_count;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_zero, p_negative, p_clr_count;
  logic [36:0] p_in_data;
  logic [1:0]  p_zero_count;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  zero_flag_pipe #(.WIDTH(64), .GROUP(4), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .zero(zero), .negative(negative), .clr_count(clr_count), .zero_count(zero_count)
  );

  zero_flag_pipe #(.WIDTH(37), .GROUP(4), .COUNT_W(2)) dut_p (
    .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .zero(p_zero), .negative(p_negative), .clr_count(p_clr_count), .zero_count(p_zero_count)
  );

  function automatic logic [63:0] rand_word();
    logic [63:0] one;
    one = 64'd1;
    case ($urandom_range(0, 3))
      0:       return 64'd0;
      1:       return one << $urandom_range(0, 63);
      2:       return {$urandom, $urandom};
      default: return 64'h8000_0000_0000_0000 | {32'd0, $urandom};
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    assertions++; if (zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_zero: got %b expected 0", zero); end
    assertions++; if (negative !== 1'b0) begin failures++; $display("[TB] FAIL reset_negative: got %b expected 0", negative); end
    assertions++; if (zero_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", zero_count); end
    assertions++; if (p_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_p_out_valid: got %b expected 0", p_out_valid); end
    assertions++; if (p_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_p_zero: got %b expected 0", p_zero); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // 0, 1, MSB-only, 0 back-to-back: expect flags three edges later, in order.
  task automatic test_stream();
    logic [63:0] s [4];
    logic [63:0] exp_d;
    s[0] = 64'd0; s[1] = 64'd1; s[2] = 64'h8000_0000_0000_0000; s[3] = 64'd0;
    out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      #1;
      if (c >= 1) begin
        if (c - 1 - (LAT - 1) >= 0 && c - 1 - (LAT - 1) < 4) begin
          exp_d = s[c - LAT];
          assertions++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", c, out_valid); end
          assertions++; if (zero !== (exp_d == 64'd0)) begin failures++; $display("[TB] FAIL stream_zero[%0d]: got %b expected %b", c, zero, (exp_d == 64'd0)); end
          assertions++; if (negative !== exp_d[63]) begin failures++; $display("[TB] FAIL stream_neg[%0d]: got %b expected %b", c, negative, exp_d[63]); end
        end else begin
          assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_idle[%0d]: got %b expected 0", c, out_valid); end
        end
      end
      in_valid = (c < 4);
      in_data  = (c < 4) ? s[c] : 64'd0;
    end
    assertions++; if (zero_count !== 8'd2) begin failures++; $display("[TB] FAIL stream_count: got %0d expected 2", zero_count); end
  endtask

  // Reset drops between clock edges with two samples in flight.
  task automatic test_async_reset();
    @(negedge clk); in_valid = 1'b1; in_data = 64'h0000_1234_0000_0000;
    @(negedge clk); in_data = 64'h8000_0000_0000_0000;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #1;
    assertions++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_valid: got %b expected 1", out_valid); end
    assertions++; if (zero_count !== 8'd2) begin failures++; $display("[TB] FAIL areset_pre_count: got %0d expected 2", zero_count); end
    #1 reset = 1'b0;
    #1;
    assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid: got %b expected 0", out_valid); end
    assertions++; if (zero_count !== 8'd0) begin failures++; $display("[TB] FAIL areset_count: got %0d expected 0", zero_count); end
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_ready: got %b expected 1", in_ready); end
    assertions++; if (zero !== 1'b0) begin failures++; $display("[TB] FAIL areset_zero: got %b expected 0", zero); end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 64'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (c == LAT) begin
        assertions++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL areset_after_valid: got %b expected 1", out_valid); end
        assertions++; if (zero !== 1'b1) begin failures++; $display("[TB] FAIL areset_after_zero: got %b expected 1", zero); end
      end else begin
        assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_after_idle[%0d]: got %b expected 0", c, out_valid); end
      end
    end
  endtask

  // Fill the pipe, stall for five cycles, then drain and check order.
  task automatic test_stall();
    logic [63:0] list [5];
    logic [63:0] q [$];
    logic [63:0] exp_d;
    int idx = 0, delivered = 0, frozen = 0, cyc = 0;
    bit acc, del;
    list[0] = 64'd0; list[1] = 64'h8000_0000_0000_0000; list[2] = 64'd5;
    list[3] = 64'd0; list[4] = 64'h8000_0000_0000_0001;
    while ((idx < 5 || q.size() > 0) && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (idx < 5);
      in_data   = (idx < 5) ? list[idx] : 64'd0;
      #1;
      if (cyc >= 3 && cyc < 8) begin
        frozen++;
        assertions++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", cyc, in_ready); end
        assertions++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", cyc, out_valid); end
        assertions++; if (zero !== (list[0] == 64'd0)) begin failures++; $display("[TB] FAIL stall_zero[%0d]: got %b expected %b", cyc, zero, (list[0] == 64'd0)); end
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        assertions++;
        if (q.size() == 0) begin
          failures++; $display("[TB] FAIL stall_dup: got extra output expected none");
        end else begin
          exp_d = q.pop_front();
          delivered++;
          if (zero !== (exp_d == 64'd0) || negative !== exp_d[63]) begin
            failures++; $display("[TB] FAIL stall_order[%0d]: got z=%b n=%b expected z=%b n=%b", delivered, zero, negative, (exp_d == 64'd0), exp_d[63]);
          end
        end
      end
      if (acc) begin q.push_back(list[idx]); idx++; end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    assertions++; if (delivered != 5) begin failures++; $display("[TB] FAIL stall_delivered: got %0d expected 5", delivered); end
    assertions++; if (frozen != 5) begin failures++; $display("[TB] FAIL stall_frozen_cycles: got %0d expected 5", frozen); end
  endtask

  // WIDTH=37 is padded to 64 bits inside the block; the flags must still
  // come out right three edges after each sample.
  task automatic test_padding();
    logic [36:0] s [4];
    logic [36:0] exp_d;
    s[0] = 37'h10_0000_0000; s[1] = 37'd0; s[2] = 37'h00_0000_8000; s[3] = 37'h0F_FFFF_FFFF;
    p_out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      #1;
      if (c >= 1) begin
        if (c - LAT >= 0 && c - LAT < 4) begin
          exp_d = s[c - LAT];
          assertions++; if (p_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL pad_valid[%0d]: got %b expected 1", c, p_out_valid); end
          assertions++; if (p_zero !== (exp_d == 37'd0)) begin failures++; $display("[TB] FAIL pad_zero[%0d]: got %b expected %b", c, p_zero, (exp_d == 37'd0)); end
          assertions++; if (p_negative !== exp_d[36]) begin failures++; $display("[TB] FAIL pad_neg[%0d]: got %b expected %b", c, p_negative, exp_d[36]); end
        end else begin
          assertions++; if (p_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL pad_idle[%0d]: got %b expected 0", c, p_out_valid); end
        end
      end
      p_in_valid = (c < 4);
      p_in_data  = (c < 4) ? s[c] : 37'd0;
    end
  endtask

  // Two-bit counter: six zero deliveries, clear lands on the sixth.
  task automatic test_saturate();
    logic [1:0] exp_cnt = 2'd0;
    int fed = 0, dels = 0, cyc = 0;
    @(negedge clk); p_clr_count = 1'b1;
    @(negedge clk); p_clr_count = 1'b0;
    #1;
    assertions++; if (p_zero_count !== 2'd0) begin failures++; $display("[TB] FAIL sat_clear: got %0d expected 0", p_zero_count); end
    p_out_ready = 1'b1;
    while (dels < 6 && cyc < 40) begin
      @(negedge clk);
      p_in_valid  = (fed < 6);
      p_in_data   = 37'd0;
      p_clr_count = p_out_valid && (dels == 5);
      #1;
      assertions++; if (p_zero_count !== exp_cnt) begin failures++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", dels, p_zero_count, exp_cnt); end
      if (p_out_valid && p_out_ready) begin
        dels++;
        if (p_clr_count) exp_cnt = 2'd0;
        else if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      end
      if (p_in_valid && p_in_ready) fed++;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    p_clr_count = 1'b0; p_in_valid = 1'b0;
    #1;
    assertions++; if (p_zero_count !== 2'd0) begin failures++; $display("[TB] FAIL sat_final: got %0d expected 0", p_zero_count); end
    assertions++; if (dels != 6) begin failures++; $display("[TB] FAIL sat_deliveries: got %0d expected 6", dels); end
  endtask

  // Random handshakes on both sides against a queue model of accepted data.
  task automatic test_random();
    logic [63:0] q [$];
    logic [63:0] exp_d;
    logic [7:0]  exp_cnt;
    int accepted = 0, cyc = 0;
    bit acc, del, exp_z;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b1;
    @(posedge clk);
    exp_cnt = 8'd0;
    while ((accepted < 1000 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      if (accepted < 1000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = rand_word();
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      clr_count = ($urandom_range(0, 299) == 0);
      #1;
      assertions++; if (zero_count !== exp_cnt) begin failures++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", cyc, zero_count, exp_cnt); end
      acc   = in_valid && in_ready;
      del   = out_valid && out_ready;
      exp_z = 1'b0;
      if (del) begin
        assertions++;
        if (q.size() == 0) begin
          failures++; $display("[TB] FAIL rand_dup[%0d]: got output expected none", cyc);
        end else begin
          exp_d = q.pop_front();
          exp_z = (exp_d == 64'd0);
          if (zero !== exp_z || negative !== exp_d[63]) begin
            failures++; $display("[TB] FAIL rand_flags[%0d]: got z=%b n=%b expected z=%b n=%b", cyc, zero, negative, exp_z, exp_d[63]);
          end
        end
      end
      if (clr_count) exp_cnt = 8'd0;
      else if (exp_z && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (acc) begin q.push_back(in_data); accepted++; end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    clr_count = 1'b0; in_valid = 1'b0;
    #1;
    assertions++; if (zero_count !== exp_cnt) begin failures++; $display("[TB] FAIL rand_final_count: got %0d expected %0d", zero_count, exp_cnt); end
    assertions++; if (q.size() != 0 || accepted != 1000) begin failures++; $display("[TB] FAIL rand_drain: got %0d pending, %0d accepted expected 0, 1000", q.size(), accepted); end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_count = 1'b0;
    p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b1; p_clr_count = 1'b0;
    test_reset();
    test_stream();
    test_async_reset();
    test_stall();
    test_padding();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
